// File: rtl/rx_sched_pkg.sv
// Shared types and defaults for the receive-channel scheduler.
// Holds the FSM encoding, default timing constants and a constant-foldable clog2.
package rx_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StSettle,
    StListen,
    StDeliver
  } sched_st_e;

  localparam int unsigned SettleCycDef = 32;
  localparam int unsigned TmoCycDef    = 6240;
  localparam int unsigned ErrLimDef    = 3;

  // Smallest r such that 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_chan_sched_if.sv
// Link-side and consumer-side signals of the receive-channel scheduler.
// master is the environment (mux/decoder/consumer) view, slave is the scheduler view.
interface rx_chan_sched_if #(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned DATA_W = 48
);
  logic [CH_NUM-1:0] chan_en;
  logic              frm_vld;
  logic              frm_crc_ok;
  logic [DATA_W-1:0] frm_data;
  logic [CH_W-1:0]   sel_ch;
  logic              dec_clr;
  logic              rd_vld;
  logic              rd_rdy;
  logic [CH_W-1:0]   rd_ch;
  logic [DATA_W-1:0] rd_data;
  logic [CH_NUM-1:0] ch_fault;
  logic [CH_NUM-1:0] ch_tmo;

  modport master (
    output chan_en, frm_vld, frm_crc_ok, frm_data, rd_rdy,
    input  sel_ch, dec_clr, rd_vld, rd_ch, rd_data, ch_fault, ch_tmo
  );

  modport slave (
    input  chan_en, frm_vld, frm_crc_ok, frm_data, rd_rdy,
    output sel_ch, dec_clr, rd_vld, rd_ch, rd_data, ch_fault, ch_tmo
  );
endinterface

// File: rtl/rx_chan_sched_rr_pick.sv
// Combinational round-robin search: first set bit of mask strictly after ptr, wrapping.
module rr_pick #(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic [CH_NUM-1:0] mask,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  logic [CH_W-1:0] hi_idx, lo_idx;
  logic            hi_any, lo_any;

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    lo_any = 1'b0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (mask[i]) begin
        if (i > int'(ptr)) begin
          hi_idx = CH_W'(i);
          hi_any = 1'b1;
        end else begin
          lo_idx = CH_W'(i);
          lo_any = 1'b1;
        end
      end
    end
    idx = hi_any ? hi_idx : lo_idx;
    any = hi_any | lo_any;
  end

endmodule

// File: rtl/rx_chan_sched.sv
// Time-shares one Manchester receive/CRC path across CH_NUM links: selects, settles,
// listens for one frame or timeout, delivers good payloads and tracks per-channel health.
module rx_chan_sched
  import rx_sched_pkg::*;
#(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned CH_W       = 2,
  parameter int unsigned DATA_W     = 48,
  parameter int unsigned SETTLE_CYC = SettleCycDef,
  parameter int unsigned TMO_CYC    = TmoCycDef,
  parameter int unsigned ERR_LIM    = ErrLimDef
) (
  input logic             clk,
  input logic             reset,
  rx_chan_sched_if.slave  bus
);

  localparam int unsigned CntMax = (TMO_CYC > SETTLE_CYC) ? TMO_CYC : SETTLE_CYC;
  localparam int unsigned CntW   = clog2(CntMax + 1);
  localparam int unsigned ErrW   = clog2(ERR_LIM + 1);

  sched_st_e         state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ErrW-1:0]   err_q [CH_NUM];
  logic [ErrW-1:0]   err_d [CH_NUM];
  logic [CH_NUM-1:0] fault_q, fault_d;
  logic [CH_NUM-1:0] tmo_q, tmo_d;
  logic [CH_NUM-1:0] good_mask;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_any;

  rr_pick #(
    .CH_NUM (CH_NUM),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .mask (bus.chan_en),
    .ptr  (ptr_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    rd_ch_d   = rd_ch_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    tmo_d     = '0;
    good_mask = '0;

    unique case (state_q)
      StIdle: begin
        if (|bus.chan_en) state_d = StSelect;
      end
      StSelect: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = '0;
          state_d = StSettle;
        end else begin
          state_d = StIdle;
        end
      end
      StSettle: begin
        if (!bus.chan_en[sel_q]) begin
          state_d = StSelect;
        end else if (cnt_q == CntW'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StListen;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StListen: begin
        // A frame beats a coincident timeout; a disabled channel is dropped silently.
        if (!bus.chan_en[sel_q]) begin
          state_d = StSelect;
        end else if (bus.frm_vld && bus.frm_crc_ok) begin
          rd_ch_d          = sel_q;
          rd_data_d        = bus.frm_data;
          err_d[sel_q]     = '0;
          good_mask[sel_q] = 1'b1;
          state_d          = StDeliver;
        end else if (bus.frm_vld || cnt_q == CntW'(TMO_CYC - 1)) begin
          if (!bus.frm_vld) tmo_d[sel_q] = 1'b1;
          if (err_q[sel_q] != ErrW'(ERR_LIM)) err_d[sel_q] = err_q[sel_q] + 1'b1;
          state_d = StSelect;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDeliver: begin
        if (bus.rd_rdy) state_d = StSelect;
      end
      default: state_d = StIdle;
    endcase

    fault_d = fault_q;
    for (int i = 0; i < CH_NUM; i++) begin
      if (good_mask[i]) fault_d[i] = 1'b0;
      else if (err_q[i] == ErrW'(ERR_LIM)) fault_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= CH_W'(CH_NUM - 1);
      sel_q     <= '0;
      cnt_q     <= '0;
      rd_ch_q   <= '0;
      rd_data_q <= '0;
      err_q     <= '{default: '0};
      fault_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      rd_ch_q   <= rd_ch_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      fault_q   <= fault_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.sel_ch   = sel_q;
  assign bus.dec_clr  = (state_q != StListen);
  assign bus.rd_vld   = (state_q == StDeliver);
  assign bus.rd_ch    = rd_ch_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.ch_fault = fault_q;
  assign bus.ch_tmo   = tmo_q;

endmodule

// File: tb/tb_rx_chan_sched.sv
// Self-checking bench for rx_chan_sched: frame vector table with a delivery scoreboard,
// plus directed sequences for timeout, stall, abort and mid-delivery reset.
module tb_rx_chan_sched;

  localparam int TMO    = 6240;
  localparam int SETTLE = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rx_chan_sched_if #(.CH_NUM(4), .CH_W(2), .DATA_W(48)) bus ();

  rx_chan_sched #(
    .CH_NUM     (4),
    .CH_W       (2),
    .DATA_W     (48),
    .SETTLE_CYC (SETTLE),
    .TMO_CYC    (TMO),
    .ERR_LIM    (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  ch;
    logic [47:0] data;
  } sb_t;

  typedef struct {
    logic [1:0]  ch;
    logic        ok;
    logic [47:0] data;
    logic [3:0]  fault;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Consumer-side scoreboard, sampled just after the negedge when inputs are settled.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && bus.rd_vld && bus.rd_rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_delivery", 64'(bus.rd_data), 64'h0);
        end else begin
          e = sb.pop_front();
          check("rd_ch", 64'(bus.rd_ch), 64'(e.ch));
          check("rd_data", 64'(bus.rd_data), 64'(e.data));
        end
      end
    end
  end

  task automatic wait_listen(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.dec_clr && n < 400);
    check("listen_reached", 64'(bus.dec_clr), 64'h0);
  endtask

  task automatic send_frame(input logic ok, input logic [47:0] d);
    bus.frm_vld    = 1'b1;
    bus.frm_crc_ok = ok;
    bus.frm_data   = d;
    @(negedge clk);
    bus.frm_vld    = 1'b0;
    bus.frm_crc_ok = 1'b0;
  endtask

  initial begin
    int          n, first, pulses;
    logic [3:0]  tmo_val;
    logic        dec_at, saw_rd, bad;
    logic [47:0] base;

    base = 48'h0000_1111_2222;
    vecs[0]  = '{2'd0, 1'b1, base, 4'b0000};
    vecs[1]  = '{2'd1, 1'b1, base, 4'b0000};
    vecs[2]  = '{2'd3, 1'b1, base, 4'b0000};
    vecs[3]  = '{2'd0, 1'b1, base, 4'b0000};
    vecs[4]  = '{2'd1, 1'b0, 48'hdead_0000_0004, 4'b0000};
    vecs[5]  = '{2'd3, 1'b1, 48'h0505_a5a5_5a5a, 4'b0000};
    vecs[6]  = '{2'd0, 1'b1, 48'h0606_ffff_0000, 4'b0000};
    vecs[7]  = '{2'd1, 1'b0, 48'hdead_0000_0007, 4'b0000};
    vecs[8]  = '{2'd3, 1'b1, 48'h0808_1234_5678, 4'b0000};
    vecs[9]  = '{2'd0, 1'b1, 48'h0909_8765_4321, 4'b0000};
    vecs[10] = '{2'd1, 1'b0, 48'hdead_0000_000a, 4'b0010};
    vecs[11] = '{2'd3, 1'b1, 48'h0b0b_0f0f_f0f0, 4'b0010};
    vecs[12] = '{2'd0, 1'b1, 48'h0c0c_c0c0_0c0c, 4'b0010};
    vecs[13] = '{2'd1, 1'b1, 48'h0d0d_1111_dddd, 4'b0000};

    bus.chan_en    = 4'b1011;
    bus.frm_vld    = 1'b0;
    bus.frm_crc_ok = 1'b0;
    bus.frm_data   = '0;
    bus.rd_rdy     = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_sel_ch", 64'(bus.sel_ch), 64'h0);
    check("rst_dec_clr", 64'(bus.dec_clr), 64'h1);
    check("rst_rd_vld", 64'(bus.rd_vld), 64'h0);
    check("rst_rd_ch", 64'(bus.rd_ch), 64'h0);
    check("rst_rd_data", 64'(bus.rd_data), 64'h0);
    check("rst_ch_fault", 64'(bus.ch_fault), 64'h0);
    check("rst_ch_tmo", 64'(bus.ch_tmo), 64'h0);
    reset = 1'b0;

    // Round-robin delivery order and consecutive-CRC-error fault tracking.
    for (int i = 0; i < 14; i++) begin
      wait_listen(n);
      if (i == 0) check("first_listen_latency", 64'(n), 64'(SETTLE + 2));
      check("vec_sel_ch", 64'(bus.sel_ch), 64'(vecs[i].ch));
      if (vecs[i].ok) sb.push_back('{vecs[i].ch, vecs[i].data});
      send_frame(vecs[i].ok, vecs[i].data);
      check("vec_rd_vld", 64'(bus.rd_vld), 64'(vecs[i].ok));
      @(negedge clk);
      check("vec_ch_fault", 64'(bus.ch_fault), 64'(vecs[i].fault));
    end

    // Silent channel 2 times out after exactly TMO listen cycles.
    bus.chan_en = 4'b0100;
    wait_listen(n);
    check("tmo_sel_ch", 64'(bus.sel_ch), 64'h2);
    first = -1; pulses = 0; saw_rd = 1'b0; tmo_val = '0; dec_at = 1'b0;
    for (int k = 1; k <= TMO + 4; k++) begin
      @(negedge clk);
      if (bus.ch_tmo != 0) begin
        pulses++;
        if (first < 0) begin
          first   = k;
          tmo_val = bus.ch_tmo;
          dec_at  = bus.dec_clr;
        end
      end
      if (bus.rd_vld) saw_rd = 1'b1;
    end
    check("tmo_cycle", 64'(first), 64'(TMO));
    check("tmo_value", 64'(tmo_val), 64'h4);
    check("tmo_pulse_count", 64'(pulses), 64'h1);
    check("tmo_back_to_select", 64'(dec_at), 64'h1);
    check("tmo_no_rd_vld", 64'(saw_rd), 64'h0);

    // Good frame on the exact timeout cycle wins over the timeout.
    wait_listen(n);
    bad = 1'b0;
    repeat (TMO - 1) begin
      @(negedge clk);
      if (bus.ch_tmo != 0) bad = 1'b1;
    end
    check("edge_no_early_tmo", 64'(bad), 64'h0);
    sb.push_back('{2'd2, 48'h4444_5555_6666});
    send_frame(1'b1, 48'h4444_5555_6666);
    check("edge_rd_vld", 64'(bus.rd_vld), 64'h1);
    check("edge_ch_tmo", 64'(bus.ch_tmo), 64'h0);
    @(negedge clk);
    check("edge_ch_tmo_after", 64'(bus.ch_tmo), 64'h0);

    // Consumer stall: offered word held, disabling the channel does not withdraw it.
    bus.rd_rdy = 1'b0;
    wait_listen(n);
    sb.push_back('{2'd2, 48'h7777_8888_9999});
    send_frame(1'b1, 48'h7777_8888_9999);
    bad = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (k == 25) bus.chan_en = 4'b0000;
      if (!bus.rd_vld || bus.rd_data !== 48'h7777_8888_9999 || bus.sel_ch !== 2'd2 ||
          !bus.dec_clr) bad = 1'b1;
      @(negedge clk);
    end
    check("stall_stable", 64'(bad), 64'h0);
    bus.rd_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_released", 64'(bus.rd_vld), 64'h0);

    // Disable during settle aborts to idle; re-enable restarts the full sequence.
    bus.chan_en = 4'b1000;
    repeat (6) @(negedge clk);
    bus.chan_en = 4'b0000;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (!bus.dec_clr || bus.rd_vld) bad = 1'b1;
    end
    check("abort_held_clear", 64'(bad), 64'h0);
    check("abort_sel_ch", 64'(bus.sel_ch), 64'h3);
    bus.chan_en = 4'b1000;
    wait_listen(n);
    check("idle_restart_latency", 64'(n), 64'(SETTLE + 2));
    check("idle_restart_sel_ch", 64'(bus.sel_ch), 64'h3);

    // Reset during delivery discards the pending word.
    bus.rd_rdy = 1'b0;
    send_frame(1'b1, 48'habcd_ef01_2345);
    check("dlv_rd_vld", 64'(bus.rd_vld), 64'h1);
    check("dlv_rd_ch", 64'(bus.rd_ch), 64'h3);
    check("dlv_rd_data", 64'(bus.rd_data), 64'habcd_ef01_2345);
    reset = 1'b1;
    #1;
    check("mid_rst_rd_vld", 64'(bus.rd_vld), 64'h0);
    check("mid_rst_rd_data", 64'(bus.rd_data), 64'h0);
    check("mid_rst_sel_ch", 64'(bus.sel_ch), 64'h0);
    check("mid_rst_dec_clr", 64'(bus.dec_clr), 64'h1);
    @(negedge clk);
    bus.chan_en = 4'b0000;
    reset = 1'b0;
    @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
